// File: rtl/proc_bypass_ctrl_pkg.sv
// Shared types for the TinyRV hazard/bypass controller: scoreboard entry and select constants.
// Entry fields are sized for the widest supported configuration; narrower configs zero-extend.
package proc_pkg;

    localparam int SB_AW_MAX = 8;
    localparam int SB_SW_MAX = 4;

    localparam int BYP_RF = 0;
    localparam int REG_X0 = 0;

    typedef struct packed {
        logic                 val;
        logic                 wen;
        logic [SB_AW_MAX-1:0] waddr;
        logic [SB_SW_MAX-1:0] rdy_stage;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/proc_bypass_ctrl_if.sv
// D-stage request and bypass/stall response bundle between decode and the hazard controller.
// Purely combinational wiring; the controller owns the slave side.
interface proc_bypass_ctrl_if #(
    parameter int NREAD = 2,
    parameter int AW    = 5,
    parameter int SW    = 2
) ();
    logic                d_val;
    logic                d_wen;
    logic [AW-1:0]       d_waddr;
    logic [SW-1:0]       d_rdy_stage;
    logic [NREAD*AW-1:0] d_rs_addr;
    logic [NREAD-1:0]    d_rs_used;
    logic                squash_D;
    logic                stall_ext;
    logic [NREAD*SW-1:0] byp_sel;
    logic                stall_D;
    logic                wen_W;
    logic [AW-1:0]       waddr_W;

    modport master (
        output d_val, d_wen, d_waddr, d_rdy_stage, d_rs_addr, d_rs_used, squash_D, stall_ext,
        input  byp_sel, stall_D, wen_W, waddr_W
    );

    modport slave (
        input  d_val, d_wen, d_waddr, d_rdy_stage, d_rs_addr, d_rs_used, squash_D, stall_ext,
        output byp_sel, stall_D, wen_W, waddr_W
    );
endinterface

// File: rtl/proc_bypass_ctrl_sb_stage.sv
// One scoreboard entry: loads the upstream entry or a bubble each cycle, holds while frozen.
// One-cycle register; async active-low clear.
module proc_sb_stage
    import proc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      load_bubble,
    input  sb_entry_t ent_in,
    output sb_entry_t ent_out
);

    sb_entry_t ent_d;
    sb_entry_t ent_q;

    always_comb begin
        ent_d = ent_q;
        if (!hold) begin
            ent_d = load_bubble ? SB_BUBBLE : ent_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= SB_BUBBLE;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign ent_out = ent_q;

endmodule

// File: rtl/proc_bypass_ctrl.sv
// Hazard/bypass controller: shifting scoreboard of in-flight writes -> per-port bypass select and D stall.
// Outputs are combinational from scoreboard + D inputs; stall_ext freezes the scoreboard only.
module proc_bypass_ctrl
    import proc_pkg::*;
#(
    parameter int NSTAGES = 3,
    parameter int NREAD   = 2,
    parameter int AW      = 5,
    parameter int SW      = $clog2(NSTAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    proc_bypass_ctrl_if.slave  bus
);

    sb_entry_t           ent    [1:NSTAGES];
    sb_entry_t           ent_in [1:NSTAGES];
    logic [NSTAGES:1]    bubble;
    sb_entry_t           d_ent;
    logic                stall_d;
    logic                issue;
    logic [NREAD-1:0]    haz_vec;
    logic [NREAD*SW-1:0] byp_sel_o;

    always_comb begin
        d_ent           = SB_BUBBLE;
        d_ent.val       = 1'b1;
        d_ent.wen       = bus.d_wen;
        d_ent.waddr     = SB_AW_MAX'(bus.d_waddr);
        d_ent.rdy_stage = SB_SW_MAX'(bus.d_rdy_stage);
    end

    // A squashed or stalled D instruction becomes a single bubble in stage 1.
    assign issue = bus.d_val & ~stall_d & ~bus.squash_D;

    for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
        if (k == 1) begin : g_head
            assign ent_in[k] = d_ent;
            assign bubble[k] = ~issue;
        end else begin : g_body
            assign ent_in[k] = ent[k-1];
            assign bubble[k] = 1'b0;
        end

        proc_sb_stage u_stage (
            .clk         (clk),
            .rst         (rst),
            .hold        (bus.stall_ext),
            .load_bubble (bubble[k]),
            .ent_in      (ent_in[k]),
            .ent_out     (ent[k])
        );
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0]    rs;
        logic [NSTAGES:1] hit;
        logic [SW-1:0]    sel;
        logic             haz;

        assign rs = bus.d_rs_addr[i*AW +: AW];

        for (genvar k = 1; k <= NSTAGES; k++) begin : g_match
            assign hit[k] = ent[k].val & ent[k].wen & bus.d_rs_used[i]
                          & (rs != AW'(REG_X0))
                          & (ent[k].waddr == SB_AW_MAX'(rs));
        end

        // Scan oldest to youngest so the youngest match overwrites; an unready
        // younger producer therefore masks any older ready one.
        always_comb begin
            sel = SW'(BYP_RF);
            haz = 1'b0;
            for (int k = NSTAGES; k >= 1; k--) begin
                if (hit[k]) begin
                    if (SB_SW_MAX'(k) >= ent[k].rdy_stage) begin
                        sel = SW'(k);
                        haz = 1'b0;
                    end else begin
                        sel = SW'(BYP_RF);
                        haz = 1'b1;
                    end
                end
            end
        end

        assign byp_sel_o[i*SW +: SW] = sel;
        assign haz_vec[i]            = haz;
    end

    assign stall_d     = bus.d_val & (|haz_vec);
    assign bus.stall_D = stall_d;
    assign bus.byp_sel = byp_sel_o;
    assign bus.wen_W   = ent[NSTAGES].val & ent[NSTAGES].wen;
    assign bus.waddr_W = ent[NSTAGES].waddr[AW-1:0];

endmodule

// File: tb/tb_proc_bypass_ctrl.sv
// Directed bench for proc_bypass_ctrl (NSTAGES=3, NREAD=2): driver queues expectations, negedge monitor checks.
module tb_proc_bypass_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    proc_bypass_ctrl_if #(.NREAD(2), .AW(5), .SW(2)) bus ();

    proc_bypass_ctrl #(.NSTAGES(3), .NREAD(2), .AW(5), .SW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      nm;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       st;
        logic       wn;
        logic [4:0] wa;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Monitor: outputs are combinational, so sample mid-cycle after inputs settle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_chk++;
            if (bus.byp_sel[1:0] === mon_e.s0 && bus.byp_sel[3:2] === mon_e.s1 &&
                bus.stall_D === mon_e.st && bus.wen_W === mon_e.wn && bus.waddr_W === mon_e.wa) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got sel0=%0d sel1=%0d stall=%b wen=%b waddr=%0d, want sel0=%0d sel1=%0d stall=%b wen=%b waddr=%0d",
                         mon_e.nm, bus.byp_sel[1:0], bus.byp_sel[3:2], bus.stall_D, bus.wen_W, bus.waddr_W,
                         mon_e.s0, mon_e.s1, mon_e.st, mon_e.wn, mon_e.wa);
            end
        end
    end

    task automatic step(input string nm, input bit rstv,
                        input bit val, input bit wen, input logic [4:0] wa, input logic [1:0] rdy,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                        input bit sq, input bit sx,
                        input logic [1:0] e0, input logic [1:0] e1, input bit est,
                        input bit ewn, input logic [4:0] ewa);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = rstv;
        bus.d_val         = val;
        bus.d_wen         = wen;
        bus.d_waddr       = wa;
        bus.d_rdy_stage   = rdy;
        bus.d_rs_addr     = {r1, r0};
        bus.d_rs_used     = used;
        bus.squash_D      = sq;
        bus.stall_ext     = sx;
        e.nm = nm; e.s0 = e0; e.s1 = e1; e.st = est; e.wn = ewn; e.wa = ewa;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input bit ewn, input logic [4:0] ewa);
        step(nm, 1, 0, 0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00, 0, 0, 2'd0, 2'd0, 0, ewn, ewa);
    endtask

    initial begin
        bus.d_val = 0; bus.d_wen = 0; bus.d_waddr = '0; bus.d_rdy_stage = '0;
        bus.d_rs_addr = '0; bus.d_rs_used = '0; bus.squash_D = 0; bus.stall_ext = 0;

        //    name          rst val wen wa  rdy r0  r1  used sq sx  e0 e1 st wn wa
        step("reset_init",   0, 1, 0, 0,  0,  5,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        // ALU chain on x5
        step("alu_c0",       1, 1, 1, 5,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("alu_c1",       1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 1, 0, 0, 0, 0);
        step("alu_c2",       1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 2, 0, 0, 0, 0);
        step("alu_c3",       1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 3, 0, 0, 1, 5);
        step("alu_c4",       1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on x7; the stalled reader also writes x12
        step("lu_load",      1, 1, 1, 7,  2,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("lu_stall",     1, 1, 1, 12, 1,  0,  7, 2'b10, 0, 0, 0, 0, 1, 0, 0);
        step("lu_bypass",    1, 1, 1, 12, 1,  0,  7, 2'b10, 0, 0, 0, 2, 0, 0, 0);
        step("lu_fwd_x12",   1, 1, 0, 0,  1, 12,  0, 2'b01, 0, 0, 1, 0, 0, 1, 7);
        idle("lu_bubble_W", 0, 0);
        idle("lu_x12_W_once", 1, 12);
        // Youngest wins, then x0
        step("yw_w1",        1, 1, 1, 3,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("yw_w2",        1, 1, 1, 3,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("yw_both_s1",   1, 1, 0, 0,  1,  3,  3, 2'b11, 0, 0, 1, 1, 0, 0, 0);
        step("yw_both_s2",   1, 1, 0, 0,  1,  3,  3, 2'b11, 0, 0, 2, 2, 0, 1, 3);
        step("x0_write",     1, 1, 1, 0,  3,  0,  0, 2'b00, 0, 0, 0, 0, 0, 1, 3);
        step("x0_read",      1, 1, 0, 0,  1,  0,  0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        idle("x0_idle", 0, 0);
        idle("x0_wen_W", 1, 0);
        // Younger unready x4 masks older ready x4
        step("un_old",       1, 1, 1, 4,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("un_young",     1, 1, 1, 4,  3,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("un_haz_s1",    1, 1, 0, 0,  1,  4,  0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
        step("un_haz_s2",    1, 1, 0, 0,  1,  4,  0, 2'b01, 0, 0, 0, 0, 1, 1, 4);
        step("un_byp_s3",    1, 1, 0, 0,  1,  4,  0, 2'b01, 0, 0, 3, 0, 0, 1, 4);
        idle("un_drain", 0, 0);
        // stall_ext freeze with x5 in stage 2
        step("sx_write",     1, 1, 1, 5,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle("sx_gap", 0, 0);
        step("sx_hold1",     1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 1, 2, 0, 0, 0, 0);
        step("sx_hold2",     1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 1, 2, 0, 0, 0, 0);
        step("sx_hold3",     1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 1, 2, 0, 0, 0, 0);
        step("sx_release",   1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 2, 0, 0, 0, 0);
        step("sx_adv3",      1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 3, 0, 0, 1, 5);
        step("sx_adv0",      1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        // squash_D on x9
        step("sq_write",     1, 1, 1, 9,  1,  0,  0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        step("sq_read",      1, 1, 0, 0,  1,  9,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        idle("sq_idle", 0, 0);
        idle("sq_no_wen_W", 0, 0);
        // squash and stall together: exactly one bubble
        step("ss_load",      1, 1, 1, 7,  3,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("ss_both",      1, 1, 1, 14, 1,  7,  0, 2'b01, 1, 0, 0, 0, 1, 0, 0);
        idle("ss_idle", 0, 0);
        idle("ss_x7_W", 1, 7);
        idle("ss_bubble_W", 0, 0);
        // Asynchronous reset mid-operation while wen_W=1 and stall_D=1
        step("rs_w5",        1, 1, 1, 5,  1,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("rs_w6",        1, 1, 1, 6,  3,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step("rs_haz",       1, 1, 0, 0,  1,  6,  0, 2'b01, 0, 0, 0, 0, 1, 0, 0);
        step("rs_pre",       1, 1, 0, 0,  1,  6,  0, 2'b01, 0, 0, 0, 0, 1, 1, 5);
        step("rs_async",     0, 1, 0, 0,  1,  6,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        step("rs_read_x5",   1, 1, 0, 0,  1,  5,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        idle("rs_after", 0, 0);

        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
